// File: rtl/ctrl_pkg.sv
// Shared types for the RV32I pipeline hazard controller.
// Holds the memory FSM state encoding, the default RAM timeout and the stage-control bundle.
// Pure declarations; no latency, no backpressure.
package ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } mem_state_t;

    localparam int RAM_TIMEOUT_DEF = 16;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic id_ex_stall;
        logic ex_mem_stall;
        logic if_id_flush;
        logic id_ex_flush;
    } stage_ctl_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller (decoder/pipe flags in, stage controls out).
// Wires only; no latency.
// The master side drives pipeline status, the slave side (controller) drives stall/flush/RAM request.
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic                  id_redirect;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_ram_read;
    logic                  mem_access;
    logic                  ram_ack;
    logic                  ram_req;
    logic                  pc_stall;
    logic                  if_id_stall;
    logic                  id_ex_stall;
    logic                  ex_mem_stall;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  bus_err;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_redirect,
        output ex_rd, ex_ram_read, mem_access, ram_ack,
        input  ram_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
        input  if_id_flush, id_ex_flush, bus_err
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_redirect,
        input  ex_rd, ex_ram_read, mem_access, ram_ack,
        output ram_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
        output if_id_flush, id_ex_flush, bus_err
    );
endinterface

// File: rtl/mem_handshake_fsm.sv
// Data-RAM req/ack sequencer with timeout; raises mem_stall while an access is outstanding.
// ram_req/mem_stall are combinational from state and inputs; ack releases the stall in the same cycle.
// After RAM_TIMEOUT unacknowledged WAIT cycles it parks in ERR (sticky bus_err) until rst.
module mem_handshake_fsm
    import ctrl_pkg::*;
#(
    parameter int RAM_TIMEOUT = RAM_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_access,
    input  logic ram_ack,
    output logic ram_req,
    output logic mem_stall,
    output logic bus_err
);
    localparam int CNT_W = (RAM_TIMEOUT > 2) ? $clog2(RAM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_TIMEOUT - 1);

    mem_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ram_req   = 1'b0;
        mem_stall = 1'b0;
        case (state)
            IDLE: begin
                if (mem_access) begin
                    ram_req = 1'b1;
                    if (!ram_ack) begin
                        mem_stall = 1'b1;
                        state_nxt = WAIT;
                        cnt_nxt   = '0;
                    end
                end
            end
            WAIT: begin
                ram_req = 1'b1;
                // A late ack wins over the timeout in the final WAIT cycle.
                if (ram_ack) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    mem_stall = 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_nxt = ERR;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            ERR: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (rst) begin
            ram_req   = 1'b0;
            mem_stall = 1'b0;
        end
    end

    assign bus_err = (state == ERR);

endmodule

// File: rtl/hazard_ctrl.sv
// RV32I 5-stage hazard controller: memory-wait stalls, load-use bubble, redirect flushes.
// All stage controls are combinational (zero latency); redirects seen during a stall are held and flushed on release.
// Priority: memory stall/ERR, then redirect (incl. pending), then load-use. HAZARD_CTRL_PERF_EN adds perf counters.
module hazard_ctrl
    import ctrl_pkg::*;
#(
    parameter int RAM_TIMEOUT = RAM_TIMEOUT_DEF,
    parameter int REG_ADDR_W  = 5
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0]   perf_stall_cycles,
    output logic [31:0]   perf_flush_count
`endif
);
    logic                  mem_stall;
    logic                  pend_redirect;
    logic                  lu;
    logic                  redirect_now;
    logic [REG_ADDR_W-1:0] ex_rd;
    stage_ctl_t            ctl;

    mem_handshake_fsm #(
        .RAM_TIMEOUT (RAM_TIMEOUT)
    ) u_mem_fsm (
        .clk        (clk),
        .rst        (rst),
        .mem_access (bus.mem_access),
        .ram_ack    (bus.ram_ack),
        .ram_req    (bus.ram_req),
        .mem_stall  (mem_stall),
        .bus_err    (bus.bus_err)
    );

    assign ex_rd = bus.ex_rd;
    assign lu = bus.ex_ram_read && (ex_rd != '0) &&
                ((bus.id_uses_rs1 && (bus.id_rs1 == ex_rd)) ||
                 (bus.id_uses_rs2 && (bus.id_rs2 == ex_rd)));
    assign redirect_now = bus.id_redirect || pend_redirect;

    // A redirect arriving while frozen must survive until the pipe moves again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_redirect <= 1'b0;
        end else if (mem_stall) begin
            pend_redirect <= pend_redirect || bus.id_redirect;
        end else begin
            pend_redirect <= 1'b0;
        end
    end

    always_comb begin
        ctl = '0;
        if (rst) begin
            ctl = '0;
        end else if (mem_stall) begin
            ctl.pc_stall     = 1'b1;
            ctl.if_id_stall  = 1'b1;
            ctl.id_ex_stall  = 1'b1;
            ctl.ex_mem_stall = 1'b1;
        end else if (redirect_now) begin
            ctl.if_id_flush = 1'b1;
            ctl.id_ex_flush = lu;
        end else if (lu) begin
            ctl.pc_stall    = 1'b1;
            ctl.if_id_stall = 1'b1;
            ctl.id_ex_flush = 1'b1;
        end
    end

    assign bus.pc_stall     = ctl.pc_stall;
    assign bus.if_id_stall  = ctl.if_id_stall;
    assign bus.id_ex_stall  = ctl.id_ex_stall;
    assign bus.ex_mem_stall = ctl.ex_mem_stall;
    assign bus.if_id_flush  = ctl.if_id_flush;
    assign bus.id_ex_flush  = ctl.id_ex_flush;

`ifdef HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (ctl.pc_stall)    perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (ctl.if_id_flush) perf_flush_count  <= perf_flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
// Expected vector bit order: {ram_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, bus_err}.
// Runs with RAM_TIMEOUT = 4; perf counters are checked when HAZARD_CTRL_PERF_EN is defined.
module tb_hazard_ctrl;
    import ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] exp_q[$];
    string      name_q[$];

    hazard_ctrl_if #(.REG_ADDR_W(5)) bus ();

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_count;
`endif

    hazard_ctrl #(
        .RAM_TIMEOUT (4),
        .REG_ADDR_W  (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef HAZARD_CTRL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [7:0] E_NONE  = 8'b0000_0000;
    localparam logic [7:0] E_REQ   = 8'b1000_0000;
    localparam logic [7:0] E_MSTL  = 8'b1111_1000;
    localparam logic [7:0] E_LU    = 8'b0110_0010;
    localparam logic [7:0] E_RDR   = 8'b0000_0100;
    localparam logic [7:0] E_RDLU  = 8'b0000_0110;
    localparam logic [7:0] E_REL   = 8'b1000_0100;
    localparam logic [7:0] E_ERR   = 8'b0111_1001;

    task automatic drive(input logic r, input logic ma, input logic ack, input logic rdr,
                         input logic exrr, input logic [4:0] exrd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic [7:0] exp_v, input string nm);
        @(posedge clk);
        #1;
        rst             = r;
        bus.mem_access  = ma;
        bus.ram_ack     = ack;
        bus.id_redirect = rdr;
        bus.ex_ram_read = exrr;
        bus.ex_rd       = exrd;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_uses_rs1 = u1;
        bus.id_uses_rs2 = u2;
        exp_q.push_back(exp_v);
        name_q.push_back(nm);
    endtask

    // Shorthand for memory/redirect-only cycles with no load in EX.
    task automatic mem_cyc(input logic ma, input logic ack, input logic rdr,
                           input logic [7:0] exp_v, input string nm);
        drive(1'b0, ma, ack, rdr, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, exp_v, nm);
    endtask

    initial begin : monitor
        logic [7:0] act;
        logic [7:0] exp_v;
        string      nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                act   = {bus.ram_req, bus.pc_stall, bus.if_id_stall, bus.id_ex_stall,
                         bus.ex_mem_stall, bus.if_id_flush, bus.id_ex_flush, bus.bus_err};
                n_checks++;
                if (act !== exp_v) begin
                    n_fail++;
                    $display("FAIL %s: got %b expected %b (ram_req,pc,if_id,id_ex,ex_mem,if_flush,ex_flush,bus_err)",
                             nm, act, exp_v);
                end
            end
        end
    end

    initial begin : stim
        bus.mem_access  = 1'b0;
        bus.ram_ack     = 1'b0;
        bus.id_redirect = 1'b0;
        bus.ex_ram_read = 1'b0;
        bus.ex_rd       = '0;
        bus.id_rs1      = '0;
        bus.id_rs2      = '0;
        bus.id_uses_rs1 = 1'b0;
        bus.id_uses_rs2 = 1'b0;

        // Reset must mask even combinational paths.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, E_NONE, "reset_gating");
        mem_cyc(1'b0, 1'b0, 1'b0, E_NONE, "idle_after_reset");

        mem_cyc(1'b1, 1'b1, 1'b0, E_REQ,  "zero_wait");
        mem_cyc(1'b0, 1'b0, 1'b0, E_NONE, "zero_wait_done");

        mem_cyc(1'b1, 1'b0, 1'b0, E_MSTL, "wait3_c1");
        mem_cyc(1'b1, 1'b0, 1'b0, E_MSTL, "wait3_c2");
        mem_cyc(1'b1, 1'b0, 1'b0, E_MSTL, "wait3_c3");
        mem_cyc(1'b1, 1'b1, 1'b0, E_REQ,  "wait3_ack");
        mem_cyc(1'b0, 1'b0, 1'b0, E_NONE, "wait3_idle");

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, E_LU, "load_use_rs2");
        mem_cyc(1'b0, 1'b0, 1'b0, E_NONE, "load_use_clear");
`ifdef HAZARD_CTRL_PERF_EN
        @(negedge clk);
        #1;
        n_checks++;
        if (perf_stall_cycles !== 32'd4 || perf_flush_count !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_counters: stall=%0d flush=%0d expected stall=4 flush=0",
                     perf_stall_cycles, perf_flush_count);
        end
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, E_NONE, "load_use_x0");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd3, 1'b1, 1'b0, E_LU,   "load_use_rs1");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd3, 1'b0, 1'b0, E_NONE, "rs1_unused");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd7, 5'd3, 1'b1, 1'b0, E_NONE, "no_load");

        mem_cyc(1'b0, 1'b0, 1'b1, E_RDR, "redirect_only");
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, E_RDLU, "redirect_and_lu");

        // Redirect in 2nd WAIT cycle, ack two cycles later (also last pre-timeout cycle).
        mem_cyc(1'b1, 1'b0, 1'b0, E_MSTL, "rdw_idle");
        mem_cyc(1'b1, 1'b0, 1'b0, E_MSTL, "rdw_wait1");
        mem_cyc(1'b1, 1'b0, 1'b1, E_MSTL, "rdw_wait2_redirect");
        mem_cyc(1'b1, 1'b0, 1'b0, E_MSTL, "rdw_wait3");
        mem_cyc(1'b1, 1'b1, 1'b0, E_REL,  "rdw_release_flush");
        mem_cyc(1'b0, 1'b0, 1'b0, E_NONE, "rdw_pend_cleared");

        mem_cyc(1'b1, 1'b0, 1'b1, E_MSTL, "dup_pend_set");
        mem_cyc(1'b1, 1'b1, 1'b1, E_REL,  "dup_single_flush");
        mem_cyc(1'b0, 1'b0, 1'b0, E_NONE, "dup_no_second");

        mem_cyc(1'b1, 1'b0, 1'b0, E_MSTL, "to_idle");
        mem_cyc(1'b1, 1'b0, 1'b0, E_MSTL, "to_wait1");
        mem_cyc(1'b1, 1'b0, 1'b0, E_MSTL, "to_wait2");
        mem_cyc(1'b1, 1'b0, 1'b0, E_MSTL, "to_wait3");
        mem_cyc(1'b1, 1'b0, 1'b0, E_MSTL, "to_wait4");
        mem_cyc(1'b1, 1'b0, 1'b0, E_ERR,  "to_err");
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, E_ERR, "err_masks_hazards");
        mem_cyc(1'b1, 1'b1, 1'b0, E_ERR,  "err_ignores_ack");
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_NONE, "err_async_reset");
        mem_cyc(1'b0, 1'b0, 1'b0, E_NONE, "post_reset_clear");
        mem_cyc(1'b1, 1'b1, 1'b0, E_REQ,  "post_reset_idle");
        mem_cyc(1'b0, 1'b0, 1'b0, E_NONE, "final_idle");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
